vc_buffer_arbiter: RTL and testbench

//  Two virtual-channel FIFOs (VC0, VC1) plus pop arbiter; the stage directly upstream of the destination output mux.

---
 rtl/vc_buffer_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_vc_buffer_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// vc_buffer_arbiter
//   Two virtual-channel FIFOs (VC0, VC1) feeding the destination output mux.
//   Each input word is steered to a VC by its top (class) bit. At most one VC
//   is popped per cycle, VC0 having strict priority over VC1. Pops stop while
//   the destination reports almost-full. A small FSM takes the almost-full
//   thresholds during INIT and reports when the buffer is idle.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   init                enter INIT and load thresholds while high
//   umbral_vc0/1        almost-full thresholds, sampled while in INIT
//   data_in, valid_in   push word and push request
//   dst_pause           destination almost-full; blocks all pops
//   data_out_vcX        popped word (0 when valid_vcX is low)
//   valid_vcX           registered pop strobe, one per popped word
//   vcX_empty/full      occupancy flags
//   vcX_almost_full     occupancy >= programmed threshold
//   fifo_error          one-cycle pulse: a push was dropped on a full VC
//   state, idle         FSM state and idle decode
//
// state    | meaning
// ---------+------------------------------------------------------------
// RESET  0 | after reset; pushes ignored, waits for init
// INIT   1 | thresholds follow umbral_* every cycle; pushes ignored
// IDLE   2 | both VCs empty; pushes accepted, no pops
// ACTIVE 3 | data buffered; pops issued when dst_pause is low
// ---------------------------------------------------------------------------
module vc_buffer_arbiter #(
  parameter int BITNUMBER = 6,
  parameter int DEPTH_VC0 = 16,
  parameter int DEPTH_VC1 = 4,
  localparam int CW0 = $clog2(DEPTH_VC0) + 1,
  localparam int CW1 = $clog2(DEPTH_VC1) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [CW0-1:0]       umbral_vc0,
  input  logic [CW1-1:0]       umbral_vc1,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 valid_in,
  input  logic                 dst_pause,
  output logic [BITNUMBER-1:0] data_out_vc0,
  output logic                 valid_vc0,
  output logic [BITNUMBER-1:0] data_out_vc1,
  output logic                 valid_vc1,
  output logic                 vc0_empty,
  output logic                 vc1_empty,
  output logic                 vc0_full,
  output logic                 vc1_full,
  output logic                 vc0_almost_full,
  output logic                 vc1_almost_full,
  output logic                 fifo_error,
  output logic [1:0]           state,
  output logic                 idle
);

  localparam int AW0 = $clog2(DEPTH_VC0);
  localparam int AW1 = $clog2(DEPTH_VC1);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW0-1:0]       count0_q, count0_d;
  logic [CW1-1:0]       count1_q, count1_d;
  logic [AW0-1:0]       wr0_q, wr0_d, rd0_q, rd0_d;
  logic [AW1-1:0]       wr1_q, wr1_d, rd1_q, rd1_d;
  logic [CW0-1:0]       thr0_q, thr0_d;
  logic [CW1-1:0]       thr1_q, thr1_d;
  logic [BITNUMBER-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
  logic                 vout0_q, vout0_d, vout1_q, vout1_d;
  logic                 err_q, err_d;
  logic [BITNUMBER-1:0] mem0_q [DEPTH_VC0];
  logic [BITNUMBER-1:0] mem0_d [DEPTH_VC0];
  logic [BITNUMBER-1:0] mem1_q [DEPTH_VC1];
  logic [BITNUMBER-1:0] mem1_d [DEPTH_VC1];

  logic full0, full1, accept_state, pop_ok;
  logic pop0, pop1, push_req0, push_req1, push0, push1;

  assign full0 = (count0_q == CW0'(DEPTH_VC0));
  assign full1 = (count1_q == CW1'(DEPTH_VC1));

  assign accept_state = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign pop_ok       = (state_q == ST_ACTIVE) && !dst_pause;

  // Pop decision uses registered counts only, so a word written this cycle
  // can never be popped in the same cycle.
  assign pop0 = pop_ok && (count0_q != '0);
  assign pop1 = pop_ok && (count0_q == '0) && (count1_q != '0);

  assign push_req0 = valid_in && accept_state && !data_in[BITNUMBER-1];
  assign push_req1 = valid_in && accept_state &&  data_in[BITNUMBER-1];

  // A pop on the same VC frees the head slot, so a full VC still takes the push.
  assign push0 = push_req0 && (!full0 || pop0);
  assign push1 = push_req1 && (!full1 || pop1);

  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr0_d    = wr0_q;
    wr1_d    = wr1_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    count0_d = count0_q;
    count1_d = count1_q;
    thr0_d   = thr0_q;
    thr1_d   = thr1_q;
    state_d  = state_q;

    if (push0) begin
      mem0_d[wr0_q] = data_in;
      wr0_d         = wr0_q + AW0'(1);
    end
    if (push1) begin
      mem1_d[wr1_q] = data_in;
      wr1_d         = wr1_q + AW1'(1);
    end
    if (pop0) rd0_d = rd0_q + AW0'(1);
    if (pop1) rd1_d = rd1_q + AW1'(1);

    if (push0 && !pop0) count0_d = count0_q + CW0'(1);
    else if (pop0 && !push0) count0_d = count0_q - CW0'(1);
    if (push1 && !pop1) count1_d = count1_q + CW1'(1);
    else if (pop1 && !push1) count1_d = count1_q - CW1'(1);

    dout0_d = pop0 ? mem0_q[rd0_q] : '0;
    dout1_d = pop1 ? mem1_q[rd1_q] : '0;
    vout0_d = pop0;
    vout1_d = pop1;
    err_d   = (push_req0 && !push0) || (push_req1 && !push1);

    if (state_q == ST_INIT) begin
      thr0_d = umbral_vc0;
      thr1_d = umbral_vc1;
    end

    case (state_q)
      ST_RESET: if (init) state_d = ST_INIT;
      ST_INIT:  if (!init) state_d = ST_IDLE;
      // A push this cycle counts as occupancy so the word is poppable next cycle.
      ST_IDLE: begin
        if (init) state_d = ST_INIT;
        else if ((count0_q != '0) || (count1_q != '0) || push0 || push1)
          state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init) state_d = ST_INIT;
        else if ((count0_q == '0) && (count1_q == '0) && !push0 && !push1)
          state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RESET;
      count0_q <= '0;
      count1_q <= '0;
      wr0_q    <= '0;
      wr1_q    <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      thr0_q   <= CW0'(DEPTH_VC0 - 1);
      thr1_q   <= CW1'(DEPTH_VC1 - 1);
      dout0_q  <= '0;
      dout1_q  <= '0;
      vout0_q  <= 1'b0;
      vout1_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count0_q <= count0_d;
      count1_q <= count1_d;
      wr0_q    <= wr0_d;
      wr1_q    <= wr1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      thr0_q   <= thr0_d;
      thr1_q   <= thr1_d;
      dout0_q  <= dout0_d;
      dout1_q  <= dout1_d;
      vout0_q  <= vout0_d;
      vout1_q  <= vout1_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters alone.
  always_ff @(posedge clk) begin
    mem0_q <= mem0_d;
    mem1_q <= mem1_d;
  end

  assign data_out_vc0    = dout0_q;
  assign data_out_vc1    = dout1_q;
  assign valid_vc0       = vout0_q;
  assign valid_vc1       = vout1_q;
  assign vc0_empty       = (count0_q == '0);
  assign vc1_empty       = (count1_q == '0);
  assign vc0_full        = full0;
  assign vc1_full        = full1;
  assign vc0_almost_full = (count0_q >= thr0_q);
  assign vc1_almost_full = (count1_q >= thr1_q);
  assign fifo_error      = err_q;
  assign state           = state_q;
  assign idle            = (state_q == ST_IDLE);

endmodule

// File: tb/tb_vc_buffer_arbiter.sv
module tb_vc_buffer_arbiter;
  localparam int BN  = 6;
  localparam int D0  = 16;
  localparam int D1  = 4;
  localparam int CW0 = 5;
  localparam int CW1 = 3;

  logic           clk = 1'b0;
  logic           reset, init, valid_in, dst_pause;
  logic [CW0-1:0] umbral_vc0;
  logic [CW1-1:0] umbral_vc1;
  logic [BN-1:0]  data_in;
  logic [BN-1:0]  data_out_vc0, data_out_vc1;
  logic           valid_vc0, valid_vc1;
  logic           vc0_empty, vc1_empty, vc0_full, vc1_full;
  logic           vc0_almost_full, vc1_almost_full, fifo_error, idle;
  logic [1:0]     state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_buffer_arbiter dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_vc0(umbral_vc0), .umbral_vc1(umbral_vc1),
    .data_in(data_in), .valid_in(valid_in), .dst_pause(dst_pause),
    .data_out_vc0(data_out_vc0), .valid_vc0(valid_vc0),
    .data_out_vc1(data_out_vc1), .valid_vc1(valid_vc1),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_full(vc0_full), .vc1_full(vc1_full),
    .vc0_almost_full(vc0_almost_full), .vc1_almost_full(vc1_almost_full),
    .fifo_error(fifo_error), .state(state), .idle(idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two queues plus the mode number.
  logic [BN-1:0] q0[$];
  logic [BN-1:0] q1[$];
  int            m_state, thr0, thr1, s0b, s1b;
  bit            m_v0, m_v1, m_err, p0, p1, pushed, m_live = 1'b0;
  logic [BN-1:0] m_d0, m_d1;

  always @(posedge clk) begin
    if (reset) begin
      q0.delete(); q1.delete();
      m_state = 0; thr0 = D0 - 1; thr1 = D1 - 1;
      m_v0 = 0; m_v1 = 0; m_d0 = '0; m_d1 = '0; m_err = 0;
    end else begin
      s0b = q0.size(); s1b = q1.size();
      p0 = (m_state == 3) && !dst_pause && (s0b > 0);
      p1 = (m_state == 3) && !dst_pause && (s0b == 0) && (s1b > 0);
      m_v0 = p0; m_v1 = p1;
      m_d0 = p0 ? q0[0] : '0;
      m_d1 = p1 ? q1[0] : '0;
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      m_err = 0; pushed = 0;
      if (valid_in && (m_state == 2 || m_state == 3)) begin
        if (!data_in[BN-1]) begin
          if (q0.size() < D0) begin q0.push_back(data_in); pushed = 1; end
          else m_err = 1;
        end else begin
          if (q1.size() < D1) begin q1.push_back(data_in); pushed = 1; end
          else m_err = 1;
        end
      end
      case (m_state)
        0: if (init) m_state = 1;
        1: begin
          thr0 = int'(umbral_vc0); thr1 = int'(umbral_vc1);
          if (!init) m_state = 2;
        end
        2: if (init) m_state = 1;
           else if (q0.size() + q1.size() > 0) m_state = 3;
        default: if (init) m_state = 1;
                 else if (s0b == 0 && s1b == 0 && !pushed) m_state = 2;
      endcase
    end
    m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("state", 32'(state), 32'(m_state));
      chk("idle", 32'(idle), 32'(m_state == 2));
      chk("valid_vc0", 32'(valid_vc0), 32'(m_v0));
      chk("data_out_vc0", 32'(data_out_vc0), 32'(m_d0));
      chk("valid_vc1", 32'(valid_vc1), 32'(m_v1));
      chk("data_out_vc1", 32'(data_out_vc1), 32'(m_d1));
      chk("vc0_empty", 32'(vc0_empty), 32'(q0.size() == 0));
      chk("vc1_empty", 32'(vc1_empty), 32'(q1.size() == 0));
      chk("vc0_full", 32'(vc0_full), 32'(q0.size() == D0));
      chk("vc1_full", 32'(vc1_full), 32'(q1.size() == D1));
      chk("vc0_almost_full", 32'(vc0_almost_full), 32'(q0.size() >= thr0));
      chk("vc1_almost_full", 32'(vc1_almost_full), 32'(q1.size() >= thr1));
      chk("fifo_error", 32'(fifo_error), 32'(m_err));
      chk("pop_exclusive", 32'(valid_vc0 & valid_vc1), 32'd0);
    end
  end

  logic [BN-1:0] exp_d [5] = '{6'h01, 6'h02, 6'h21, 6'h22, 6'h23};
  bit            exp_ch [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1; init = 0; umbral_vc0 = '0; umbral_vc1 = '0;
    data_in = '0; valid_in = 0; dst_pause = 0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_vc0_empty", 32'(vc0_empty), 32'd1);
    chk("rst_vc0_af", 32'(vc0_almost_full), 32'd0);

    // 1: RESET -> INIT -> IDLE with thresholds 12 / 3
    reset = 0; init = 1; umbral_vc0 = 5'd12; umbral_vc1 = 3'd3;
    @(negedge clk);
    chk("t1_init", 32'(state), 32'd1);
    init = 0;
    @(negedge clk);
    chk("t1_idle_state", 32'(state), 32'd2);
    chk("t1_idle", 32'(idle), 32'd1);
    chk("t1_empties", 32'({vc0_empty, vc1_empty}), 32'd3);

    // 2: one word per VC, back to back
    valid_in = 1; data_in = 6'h05;
    @(negedge clk);
    chk("t2_active", 32'(state), 32'd3);
    data_in = 6'h25;
    @(negedge clk);
    chk("t2_v0", 32'(valid_vc0), 32'd1);
    chk("t2_d0", 32'(data_out_vc0), 32'h05);
    chk("t2_v1_low", 32'(valid_vc1), 32'd0);
    valid_in = 0;
    @(negedge clk);
    chk("t2_v1", 32'(valid_vc1), 32'd1);
    chk("t2_d1", 32'(data_out_vc1), 32'h25);
    chk("t2_v0_low", 32'(valid_vc0), 32'd0);
    @(negedge clk);
    chk("t2_back_idle", 32'(state), 32'd2);

    // 3: fill VC0 under pause, then overflow once
    dst_pause = 1;
    for (int i = 0; i < 17; i++) begin
      valid_in = 1; data_in = 6'h10 | 6'(i % 16);
      @(negedge clk);
      if (i == 10) chk("t3_af_at11", 32'(vc0_almost_full), 32'd0);
      if (i == 11) chk("t3_af_at12", 32'(vc0_almost_full), 32'd1);
      if (i == 14) chk("t3_full_at15", 32'(vc0_full), 32'd0);
      if (i == 15) chk("t3_full_at16", 32'(vc0_full), 32'd1);
      if (i == 16) chk("t3_overflow_err", 32'(fifo_error), 32'd1);
    end
    valid_in = 0;
    @(negedge clk);
    chk("t3_err_pulse_end", 32'(fifo_error), 32'd0);
    chk("t3_still_full", 32'(vc0_full), 32'd1);

    // drain the 16 words, then wait for IDLE
    dst_pause = 0;
    repeat (17) @(negedge clk);
    chk("t4_drained_idle", 32'(state), 32'd2);

    // 4: strict priority and FIFO order
    dst_pause = 1;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1;
      data_in = (i < 3) ? 6'(6'h21 + i) : 6'(6'h01 + i - 3);
      @(negedge clk);
    end
    chk("t4_vc1_af", 32'(vc1_almost_full), 32'd1);
    chk("t4_vc1_not_full", 32'(vc1_full), 32'd0);
    valid_in = 0; dst_pause = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!exp_ch[k]) begin
        chk("t4_pop_v0", 32'(valid_vc0), 32'd1);
        chk("t4_pop_d0", 32'(data_out_vc0), 32'(exp_d[k]));
      end else begin
        chk("t4_pop_v1", 32'(valid_vc1), 32'd1);
        chk("t4_pop_d1", 32'(data_out_vc1), 32'(exp_d[k]));
      end
    end
    @(negedge clk);
    chk("t4_no_valid", 32'({valid_vc0, valid_vc1}), 32'd0);

    // 5: full VC0 with push+pop every cycle
    dst_pause = 1;
    for (int i = 0; i < 16; i++) begin
      valid_in = 1; data_in = 6'(i);
      @(negedge clk);
    end
    dst_pause = 0;
    for (int j = 0; j < 10; j++) begin
      valid_in = 1; data_in = 6'(16 + j);
      @(negedge clk);
      chk("t5_v0", 32'(valid_vc0), 32'd1);
      chk("t5_d0", 32'(data_out_vc0), 32'(j));
      chk("t5_no_err", 32'(fifo_error), 32'd0);
      chk("t5_full", 32'(vc0_full), 32'd1);
    end
    valid_in = 0;
    @(negedge clk);
    chk("t6_pre_v0", 32'(valid_vc0), 32'd1);
    chk("t6_pre_d0", 32'(data_out_vc0), 32'd10);

    // 6: reset while popping
    reset = 1;
    @(negedge clk);
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_v0", 32'(valid_vc0), 32'd0);
    chk("t6_d0", 32'(data_out_vc0), 32'd0);
    chk("t6_empty", 32'(vc0_empty), 32'd1);
    chk("t6_full", 32'(vc0_full), 32'd0);
    chk("t6_err", 32'(fifo_error), 32'd0);

    // push in RESET is dropped; threshold 0 forces almost_full
    reset = 0; valid_in = 1; data_in = 6'h07;
    @(negedge clk);
    chk("t7_drop_in_reset", 32'(vc0_empty), 32'd1);
    valid_in = 0; init = 1; umbral_vc1 = 3'd0;
    @(negedge clk);
    init = 0;
    @(negedge clk);
    chk("t7_idle", 32'(state), 32'd2);
    chk("t7_thr0_af", 32'(vc1_almost_full), 32'd1);
    chk("t7_vc1_empty", 32'(vc1_empty), 32'd1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
